bsg_link_token_sched: RTL and testbench
=======================================

BSG_LINK_TOKEN_SCHED -- requirements
Module: bsg_link_token_sched

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- width_p, 16, flit data width.
- credits_p, 8, credits per channel; equals downstream buffer depth per channel.
- decimation_p, 4, credits restored per token pulse.
- init_cycles_p, 4, quiet cycles after reset before first send.

REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1, sole clock.
- reset_n_i, in, 1, asynchronous active-low reset.
- req_v_i, in, 2, per-channel flit valid.
- req_data_i, in, 2*width_p, per-channel flit; channel i in bits [i*width_p +: width_p].
- req_ready_o, out, 2, per-channel accept.
- link_v_o, out, 1, registered link flit valid.
- link_data_o, out, width_p, registered link flit.
- link_ch_o, out, 1, channel id of link_data_o.
- link_ready_i, in, 1, link consumer accept.
- token_i, in, 2, one-cycle token-return pulse per channel.
- flush_i, in, 1, level request to stop granting and drain outstanding credits.
- flush_done_o, out, 1, one-cycle pulse when drain completes.
- credit_o, out, 2*clog2(credits_p+1), per-channel credit counts.
- overflow_o, out, 1, sticky credit-overflow error.

Function
REQ-003 The FSM SHALL have three states: INIT, RUN and DRAIN.
- INIT: count init_cycles_p cycles, then go to RUN.
- RUN: go to DRAIN when flush_i=1.
- DRAIN: go to RUN when both credits equal credits_p and link_v_o=0; pulse flush_done_o for 1 cycle on this transition.

REQ-004 Channel i SHALL be eligible only when all of the following hold:
- state is RUN;
- req_v_i[i]=1;
- credit[i]>0;
- the output slot is free (link_v_o=0 or link_ready_i=1).

REQ-005 Round-robin arbitration:
- If only one channel is eligible, grant it.
- If both are eligible, grant the channel that is not last_grant.
- last_grant updates on every grant.

REQ-006 req_ready_o[i] SHALL be combinational and equal to grant[i]; at most one bit is set per cycle.

REQ-007 A handshake occurs when req_v_i[i]=1 and req_ready_o[i]=1. On a handshake:
- the next cycle shows link_v_o=1, link_data_o equal to that channel's flit, and link_ch_o=i (latency 1 cycle);
- credit[i] decrements by 1.

REQ-008 link_v_o, link_data_o and link_ch_o SHALL hold stable while link_v_o=1 and link_ready_i=0. link_v_o SHALL clear after link_ready_i=1 unless a new grant occurs in the same cycle.

REQ-009 Each token_i[i] pulse SHALL add decimation_p to credit[i]. This applies in every state.

REQ-010 On a simultaneous grant and token on the same channel, the next credit SHALL be credit - 1 + decimation_p.

REQ-011 The credit sum SHALL be computed one bit wider than the counter. If the result exceeds credits_p:
- clamp the credit to credits_p;
- set overflow_o=1, which stays set until reset.

REQ-012 Grants SHALL be zero in INIT and DRAIN. A flit already in the output register SHALL still complete its handshake in DRAIN.

REQ-013 If flush_i=1 while credits are already full and link_v_o=0, the FSM SHALL go RUN -> DRAIN -> RUN. flush_done_o pulses on the cycle after entering DRAIN.

REQ-014 While flush_i remains 1 after DRAIN completes, RUN SHALL re-enter DRAIN on the next cycle. flush_done_o pulses again each time a drain completes.

REQ-015 credit_o SHALL reflect the registered counters; it is not bypassed.

Reset
REQ-016 When reset_n_i=0, all of the following SHALL be set asynchronously:
- state=INIT, init counter=0;
- both credits=credits_p;
- last_grant=1, so channel 0 wins the first tie;
- link_v_o=0, link_data_o=0, link_ch_o=0;
- flush_done_o=0, overflow_o=0.

REQ-017 Reset SHALL be released synchronously in effect: the first counted INIT cycle is the first clk_i rising edge with reset_n_i=1.

REQ-018 Assertion of reset_n_i mid-operation SHALL discard any pending link flit.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Scenario 1, reset and INIT: release reset with req_v_i=2'b11. Required: req_ready_o=0 for 4 cycles; on cycle 5 ch0 is granted; next cycle link_v_o=1, link_ch_o=0.
- Scenario 2, fairness: link_ready_i=1, req_v_i=2'b11. Required: grants alternate 0,1,0,1,...; after 16 grants both credits are 0 and req_ready_o=0.
- Scenario 3, credit return: ch0 has credits 0; pulse token_i[0]. Required: credit[0]=4 and exactly 4 further ch0 grants before stall. A token and a grant in the same cycle at credit 1 gives credit 4.
- Scenario 4, backpressure: link_ready_i=0 for 5 cycles with ch1 flit 0xBEEF held. Required: link_data_o=0xBEEF and link_ch_o=1 stable throughout; no grants; the flit is consumed on the cycle link_ready_i=1.
- Scenario 5, flush: with 3 ch0 credits outstanding, assert flush_i. Required: no grants; after 1 token (credit 9 exceeds 8) credit clamps to 8 and overflow_o=1; flush_done_o pulses once; RUN resumes after flush_i is deasserted.
- Scenario 6, reset mid-flit: link_v_o=1 and reset_n_i is asserted. Required: link_v_o=0 immediately; credits=8; state=INIT.

Source files
------------

// File: rtl/bsg_link_token_sched_if.sv
// Handshake, link and credit bundle for the two-channel token-credit link scheduler.
// master: scheduler side; slave: requesters, link consumer and token source.
interface bsg_link_token_sched_if #(
  parameter int unsigned width_p    = 16,
  parameter int unsigned credit_w_p = 4
);
  logic [1:0]              req_v_i;
  logic [2*width_p-1:0]    req_data_i;
  logic [1:0]              req_ready_o;
  logic                    link_v_o;
  logic [width_p-1:0]      link_data_o;
  logic                    link_ch_o;
  logic                    link_ready_i;
  logic [1:0]              token_i;
  logic                    flush_i;
  logic                    flush_done_o;
  logic [2*credit_w_p-1:0] credit_o;
  logic                    overflow_o;

  modport master (
    input  req_v_i, req_data_i, link_ready_i, token_i, flush_i,
    output req_ready_o, link_v_o, link_data_o, link_ch_o, flush_done_o, credit_o, overflow_o
  );

  modport slave (
    output req_v_i, req_data_i, link_ready_i, token_i, flush_i,
    input  req_ready_o, link_v_o, link_data_o, link_ch_o, flush_done_o, credit_o, overflow_o
  );
endinterface

// File: rtl/bsg_link_token_sched.sv
// Two-channel round-robin link scheduler with per-channel credit counters,
// token-based credit return and a flush/drain handshake.
module bsg_link_token_sched #(
  parameter int unsigned width_p       = 16,
  parameter int unsigned credits_p     = 8,
  parameter int unsigned decimation_p  = 4,
  parameter int unsigned init_cycles_p = 4
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bsg_link_token_sched_if.master bus
);
  localparam int unsigned CW = $clog2(credits_p + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned IW = (init_cycles_p > 1) ? $clog2(init_cycles_p) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          init_cnt_q, init_cnt_d;
  logic                   flush_done_q, flush_done_d;
  logic [1:0][CW-1:0]     credit_q, credit_d;
  logic [1:0][SW-1:0]     sum_c;
  logic                   ovf_c;
  logic                   overflow_q;
  logic                   last_grant_q;
  logic                   link_v_q;
  logic [width_p-1:0]     link_data_q;
  logic                   link_ch_q;
  logic [1:0]             elig_c, grant_c;
  logic                   slot_free_c;
  logic                   credits_full_c;

  assign credits_full_c = (credit_q[0] == CW'(credits_p)) && (credit_q[1] == CW'(credits_p));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == IW'(init_cycles_p - 1)) state_d = ST_RUN;
        else                                      init_cnt_d = init_cnt_q + IW'(1);
      end
      ST_RUN: begin
        if (bus.flush_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (credits_full_c && !link_v_q) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Eligibility and round-robin grant; a tie goes to the channel not granted last.
  always_comb begin
    slot_free_c = !link_v_q || bus.link_ready_i;
    for (int i = 0; i < 2; i++) begin
      elig_c[i] = (state_q == ST_RUN) && bus.req_v_i[i] && (credit_q[i] != '0) && slot_free_c;
    end
    if (elig_c == 2'b11) grant_c = last_grant_q ? 2'b01 : 2'b10;
    else                 grant_c = elig_c;
  end

  // Credit update is one bit wide of the counter so a token overshoot is caught and clamped.
  always_comb begin
    ovf_c = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sum_c[i] = {1'b0, credit_q[i]}
               + (bus.token_i[i] ? SW'(decimation_p) : SW'(0))
               - SW'(grant_c[i]);
      if (sum_c[i] > SW'(credits_p)) begin
        credit_d[i] = CW'(credits_p);
        ovf_c       = 1'b1;
      end else begin
        credit_d[i] = sum_c[i][CW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_q     <= {2{CW'(credits_p)}};
      overflow_q   <= 1'b0;
      last_grant_q <= 1'b1;
      link_v_q     <= 1'b0;
      link_data_q  <= '0;
      link_ch_q    <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      overflow_q <= overflow_q | ovf_c;
      if (|grant_c) begin
        last_grant_q <= grant_c[1];
        link_v_q     <= 1'b1;
        link_ch_q    <= grant_c[1];
        link_data_q  <= grant_c[1] ? bus.req_data_i[width_p +: width_p]
                                   : bus.req_data_i[0 +: width_p];
      end else if (bus.link_ready_i) begin
        link_v_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o  = grant_c;
  assign bus.link_v_o     = link_v_q;
  assign bus.link_data_o  = link_data_q;
  assign bus.link_ch_o    = link_ch_q;
  assign bus.flush_done_o = flush_done_q;
  assign bus.credit_o     = credit_q;
  assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_bsg_link_token_sched.sv
// Directed bench for bsg_link_token_sched: expected link flits are queued as stimulus
// is issued and a negedge monitor retires them as the link consumes them.
module tb_bsg_link_token_sched;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_link_token_sched_if #(.width_p(W), .credit_w_p(CW)) bus();

  bsg_link_token_sched #(
    .width_p(W), .credits_p(8), .decimation_p(4), .init_cycles_p(4)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int n0 = 0;
  int n1 = 0;
  logic [15:0] d0, d1;
  logic [16:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic ch, input logic [15:0] d);
    sb.push_back({ch, d});
  endtask

  // One clock: record handshakes at negedge, advance source data after the edge.
  task automatic tick();
    logic [1:0] hs;
    @(negedge clk);
    hs = bus.req_ready_o & bus.req_v_i;
    @(posedge clk);
    #1;
    if (hs[0]) begin d0 = d0 + 16'd1; n0++; end
    if (hs[1]) begin d1 = d1 + 16'd1; n1++; end
    bus.req_data_i = {d1, d0};
  endtask

  task automatic set_d1(input logic [15:0] v);
    d1 = v;
    bus.req_data_i = {d1, d0};
  endtask

  // Scoreboard monitor: every consumed link flit must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.link_v_o && bus.link_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL link_unexpected: got ch%0d %0h expected nothing (t=%0t)",
                 bus.link_ch_o, bus.link_data_o, $time);
      end else begin
        chk("link_flit", 32'({bus.link_ch_o, bus.link_data_o}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int pulses;
    bus.req_v_i      = 2'b00;
    bus.token_i      = 2'b00;
    bus.flush_i      = 1'b0;
    bus.link_ready_i = 1'b1;
    d0 = 16'hA000;
    d1 = 16'hB000;
    bus.req_data_i = {d1, d0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_link_v",     32'(bus.link_v_o),     32'd0);
    chk("rst_link_ch",    32'(bus.link_ch_o),    32'd0);
    chk("rst_link_data",  32'(bus.link_data_o),  32'd0);
    chk("rst_credit",     32'(bus.credit_o),     32'h88);
    chk("rst_overflow",   32'(bus.overflow_o),   32'd0);
    chk("rst_flush_done", 32'(bus.flush_done_o), 32'd0);

    // Reset release with both channels requesting; then alternating grants.
    bus.req_v_i = 2'b11;
    for (int k = 0; k < 8; k++) begin
      push(1'b0, 16'hA000 + 16'(k));
      push(1'b1, 16'hB000 + 16'(k));
    end
    #1 rst_n = 1'b1;
    #1 chk("init_ready_c1", 32'(bus.req_ready_o), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("init_ready", 32'(bus.req_ready_o), 32'd0);
    end
    tick();
    chk("first_grant_ready", 32'(bus.req_ready_o), 32'b01);
    tick();
    chk("first_link_v",  32'(bus.link_v_o),  32'd1);
    chk("first_link_ch", 32'(bus.link_ch_o), 32'd0);
    for (int k = 0; k < 40 && (n0 + n1) < 16; k++) tick();
    chk("fair_grants",  32'(n0 + n1),          32'd16);
    chk("fair_credit",  32'(bus.credit_o),     32'h00);
    chk("fair_stall",   32'(bus.req_ready_o),  32'd0);
    bus.req_v_i = 2'b00;

    // Token return on ch0: exactly four more grants, then stall.
    bus.req_v_i = 2'b01;
    bus.token_i = 2'b01;
    tick();
    bus.token_i = 2'b00;
    chk("tok_credit", 32'(bus.credit_o), 32'h04);
    for (int k = 8; k < 12; k++) push(1'b0, 16'hA000 + 16'(k));
    base = n0;
    repeat (10) tick();
    chk("tok_grants",       32'(n0 - base),       32'd4);
    chk("tok_credit_empty", 32'(bus.credit_o),    32'h00);
    chk("tok_stall",        32'(bus.req_ready_o), 32'd0);

    // Token and grant in the same cycle at credit 1.
    bus.token_i = 2'b01;
    tick();
    bus.token_i = 2'b00;
    for (int k = 12; k < 16; k++) push(1'b0, 16'hA000 + 16'(k));
    repeat (3) tick();
    chk("tg_credit1", 32'(bus.credit_o), 32'h01);
    bus.token_i = 2'b01;
    tick();
    bus.token_i = 2'b00;
    bus.req_v_i = 2'b00;
    chk("tg_credit4", 32'(bus.credit_o), 32'h04);

    // Backpressure on a held ch1 flit.
    bus.token_i = 2'b10;
    tick();
    bus.token_i = 2'b00;
    chk("bp_credit", 32'(bus.credit_o), 32'h44);
    set_d1(16'hBEEF);
    bus.link_ready_i = 1'b0;
    bus.req_v_i      = 2'b10;
    push(1'b1, 16'hBEEF);
    tick();
    base = n1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_link_v",    32'(bus.link_v_o),    32'd1);
      chk("bp_link_data", 32'(bus.link_data_o), 32'hBEEF);
      chk("bp_link_ch",   32'(bus.link_ch_o),   32'd1);
      chk("bp_ready",     32'(bus.req_ready_o), 32'd0);
      tick();
    end
    chk("bp_no_grants", 32'(n1 - base), 32'd0);
    bus.link_ready_i = 1'b1;
    bus.req_v_i      = 2'b00;
    tick();
    chk("bp_released",      32'(bus.link_v_o), 32'd0);
    chk("bp_credit_after",  32'(bus.credit_o), 32'h34);

    // Bring ch1 to full and ch0 to 5 (3 outstanding).
    bus.req_v_i = 2'b10;
    for (int k = 0; k < 3; k++) push(1'b1, 16'hBEF0 + 16'(k));
    repeat (3) tick();
    bus.req_v_i = 2'b00;
    bus.token_i = 2'b10;
    repeat (2) tick();
    bus.token_i = 2'b01;
    tick();
    bus.token_i = 2'b00;
    for (int k = 0; k < 3; k++) push(1'b0, 16'hA010 + 16'(k));
    bus.req_v_i = 2'b01;
    repeat (3) tick();
    bus.req_v_i = 2'b00;
    chk("pre_flush_credit",   32'(bus.credit_o),   32'h85);
    chk("pre_flush_overflow", 32'(bus.overflow_o), 32'd0);

    // Flush: no grants in DRAIN, overshooting token clamps and flags overflow.
    bus.flush_i = 1'b1;
    tick();
    bus.req_v_i = 2'b11;
    #1 chk("drain_ready0", 32'(bus.req_ready_o), 32'd0);
    tick();
    chk("drain_ready1", 32'(bus.req_ready_o),  32'd0);
    chk("drain_done0",  32'(bus.flush_done_o), 32'd0);
    bus.token_i = 2'b01;
    tick();
    bus.token_i = 2'b00;
    bus.flush_i = 1'b0;
    #1;
    chk("drain_clamp",    32'(bus.credit_o),     32'h88);
    chk("drain_overflow", 32'(bus.overflow_o),   32'd1);
    chk("drain_done1",    32'(bus.flush_done_o), 32'd0);
    chk("drain_ready2",   32'(bus.req_ready_o),  32'd0);
    tick();
    chk("flush_done_pulse", 32'(bus.flush_done_o), 32'd1);
    chk("run_resumed",      32'(bus.req_ready_o),  32'b10);
    bus.req_v_i = 2'b00;
    tick();
    chk("flush_done_clear", 32'(bus.flush_done_o), 32'd0);

    // Held flush with full credits cycles RUN/DRAIN, pulsing every second cycle.
    bus.flush_i = 1'b1;
    pulses = 0;
    repeat (8) begin
      tick();
      pulses += int'(bus.flush_done_o);
    end
    bus.flush_i = 1'b0;
    chk("flush_held_pulses", 32'(pulses), 32'd4);
    tick();
    chk("overflow_sticky", 32'(bus.overflow_o), 32'd1);

    // Reset mid-flit discards the pending flit and restarts INIT.
    bus.link_ready_i = 1'b0;
    bus.req_v_i      = 2'b01;
    tick();
    chk("mid_link_v_pre", 32'(bus.link_v_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_link_v",   32'(bus.link_v_o),    32'd0);
    chk("mid_rst_credit",   32'(bus.credit_o),    32'h88);
    chk("mid_rst_ready",    32'(bus.req_ready_o), 32'd0);
    chk("mid_rst_overflow", 32'(bus.overflow_o),  32'd0);
    bus.link_ready_i = 1'b1;
    rst_n = 1'b1;
    #1 chk("reinit_ready_c1", 32'(bus.req_ready_o), 32'd0);
    push(1'b0, d0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("reinit_ready", 32'(bus.req_ready_o), 32'd0);
    end
    tick();
    chk("reinit_grant", 32'(bus.req_ready_o), 32'b01);
    tick();
    bus.req_v_i = 2'b00;
    chk("reinit_link_v", 32'(bus.link_v_o), 32'd1);
    repeat (2) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
